// File: rtl/operand_fetch.sv
// operand_fetch: operand read and hazard resolution stage between decode and EX.
// Holds one decoded instruction in a registered output slot with a valid/ready
// handshake on both sides.
// Build option: define OPERAND_FETCH_FWD_EN to forward from EX/MEM/WB; only a
// load sitting in EX then has to wait. With the macro undefined, operands always
// come from the register file, and any in-flight write to a used source stalls.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_rs1,
  input  logic [2:0]  in_rs2,
  input  logic [2:0]  in_ws,
  input  logic        in_use_rs1,
  input  logic        in_use_rs2,
  input  logic        in_we,
  input  logic        in_is_load,
  output logic [2:0]  rf_rs1,
  output logic [2:0]  rf_rs2,
  input  logic [15:0] rf_rd1,
  input  logic [15:0] rf_rd2,
  input  logic [15:0] ex_result,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  mem_ws,
  input  logic [15:0] mem_wd,
  input  logic        wb_we,
  input  logic [2:0]  wb_ws,
  input  logic [15:0] wb_wd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_op1,
  output logic [15:0] out_op2,
  output logic [2:0]  out_ws,
  output logic        out_we,
  output logic        out_is_load,
  output logic [15:0] stall_cnt
);

  logic        ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic        stall;
  logic        xfer;
  logic [15:0] op1_sel, op2_sel;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // Producer matches per source; an unused operand never matches anything.
  always_comb begin
    ex_m1  = in_use_rs1 & out_valid & out_we & (out_ws == in_rs1);
    ex_m2  = in_use_rs2 & out_valid & out_we & (out_ws == in_rs2);
    mem_m1 = in_use_rs1 & mem_valid & mem_we & (mem_ws == in_rs1);
    mem_m2 = in_use_rs2 & mem_valid & mem_we & (mem_ws == in_rs2);
    wb_m1  = in_use_rs1 & wb_we & (wb_ws == in_rs1);
    wb_m2  = in_use_rs2 & wb_we & (wb_ws == in_rs2);
  end

`ifdef OPERAND_FETCH_FWD_EN
  // Forwarding mux, youngest producer first; a load in EX has no data yet.
  always_comb begin
    stall = out_is_load & (ex_m1 | ex_m2);
    if (ex_m1)       op1_sel = ex_result;
    else if (mem_m1) op1_sel = mem_wd;
    else if (wb_m1)  op1_sel = wb_wd;
    else             op1_sel = rf_rd1;
    if (ex_m2)       op2_sel = ex_result;
    else if (mem_m2) op2_sel = mem_wd;
    else if (wb_m2)  op2_sel = wb_wd;
    else             op2_sel = rf_rd2;
  end
`else
  // No bypass paths: wait until every pending write has landed in the file.
  always_comb begin
    stall   = ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2;
    op1_sel = rf_rd1;
    op2_sel = rf_rd2;
  end

  // Data inputs only feed the bypass mux, which is absent in this build.
  logic fwd_unused;
  assign fwd_unused = ^{ex_result, mem_wd, wb_wd};
`endif

  assign in_ready = !stall & (!out_valid | out_ready);
  assign xfer     = in_valid & in_ready;

  // Output slot: capture on transfer, drain to a bubble, hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_ws      <= '0;
      out_we      <= 1'b0;
      out_is_load <= 1'b0;
    end else if (xfer) begin
      out_valid   <= 1'b1;
      out_op1     <= op1_sel;
      out_op2     <= op2_sel;
      out_ws      <= in_ws;
      out_we      <= in_we;
      out_is_load <= in_is_load;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Saturating count of cycles where decode offered an instruction we refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against a
// cycle-level reference model. Follows OPERAND_FETCH_FWD_EN like the design.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_rs1, in_rs2, in_ws;
  logic        in_use_rs1, in_use_rs2, in_we, in_is_load;
  logic [2:0]  rf_rs1, rf_rs2;
  logic [15:0] rf_rd1, rf_rd2;
  logic [15:0] ex_result;
  logic        mem_valid, mem_we;
  logic [2:0]  mem_ws;
  logic [15:0] mem_wd;
  logic        wb_we;
  logic [2:0]  wb_ws;
  logic [15:0] wb_wd;
  logic        out_valid, out_ready;
  logic [15:0] out_op1, out_op2;
  logic [2:0]  out_ws;
  logic        out_we, out_is_load;
  logic [15:0] stall_cnt;

  logic [15:0] regs [8];
  int total = 0;
  int bad = 0;

  // reference model state (what the output slot should hold)
  logic        m_valid, m_we, m_load;
  logic [15:0] m_op1, m_op2;
  logic [2:0]  m_ws;
  int          m_cnt;

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_rs1];
  assign rf_rd2 = regs[rf_rs2];

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ws(in_ws),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_we(in_we), .in_is_load(in_is_load),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_we(mem_we), .mem_ws(mem_ws), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_ws(wb_ws), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_ws(out_ws), .out_we(out_we), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  task automatic idle;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_ws = 0;
    in_use_rs1 = 0; in_use_rs2 = 0; in_we = 0; in_is_load = 0;
    out_ready = 1; ex_result = 0;
    mem_valid = 0; mem_we = 0; mem_ws = 0; mem_wd = 0;
    wb_we = 0; wb_ws = 0; wb_wd = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); idle; reset = 1;
    @(posedge clk); #1;
    @(negedge clk); reset = 0;
  endtask

  // --- reference model: value a used source should receive, and whether it must wait
  function automatic logic [15:0] pick(input logic [2:0] r);
`ifdef OPERAND_FETCH_FWD_EN
    if (m_valid && m_we && m_ws == r) return ex_result;
    if (mem_valid && mem_we && mem_ws == r) return mem_wd;
    if (wb_we && wb_ws == r) return wb_wd;
`endif
    return regs[r];
  endfunction

  function automatic logic blocks(input logic [2:0] r);
`ifdef OPERAND_FETCH_FWD_EN
    return m_valid && m_we && m_ws == r && m_load;
`else
    return (m_valid && m_we && m_ws == r) || (mem_valid && mem_we && mem_ws == r) || (wb_we && wb_ws == r);
`endif
  endfunction

  task automatic test_reset;
    @(negedge clk); idle; reset = 1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", out_valid); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", stall_cnt); end
    @(negedge clk); reset = 0;
    in_valid = 1; in_ws = 5; in_we = 1; in_is_load = 1; regs[0] = 16'hA0A0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_op1 !== 16'hA0A0) begin bad++; $display("FAIL pre_reset_load got=%h/%h want=1/a0a0", out_valid, out_op1); end
    @(negedge clk); reset = 1; in_ws = 6;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_op1 !== 16'h0 || out_op2 !== 16'h0 || out_ws !== 3'd0 ||
        out_we !== 1'b0 || out_is_load !== 1'b0 || stall_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_priority got v=%h op1=%h op2=%h ws=%h we=%h ld=%h cnt=%h want all 0",
                      out_valid, out_op1, out_op2, out_ws, out_we, out_is_load, stall_cnt);
    end
    @(negedge clk); reset = 0; idle;
  endtask

  task automatic test_basic;
    @(negedge clk); idle;
    regs[2] = 16'h0011; regs[3] = 16'h0022;
    in_valid = 1; in_rs1 = 2; in_rs2 = 3; in_use_rs1 = 1; in_use_rs2 = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%h want=1", in_ready); end
    total++; if (rf_rs1 !== 3'd2 || rf_rs2 !== 3'd3) begin bad++; $display("FAIL rf_addr got=%h/%h want=2/3", rf_rs1, rf_rs2); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_op1 !== 16'h0011 || out_op2 !== 16'h0022) begin
      bad++; $display("FAIL basic_ops got v=%h %h %h want 1 0011 0022", out_valid, out_op1, out_op2); end
    @(negedge clk); idle; regs[2] = 16'hFFFF;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_op1 !== 16'h0011) begin
      bad++; $display("FAIL bubble got v=%h op1=%h want 0 0011", out_valid, out_op1); end
  endtask

  task automatic test_forward_ex;
    do_reset;
    @(negedge clk); idle; in_valid = 1; in_ws = 1; in_we = 1;
    @(posedge clk);
    @(negedge clk); idle; in_valid = 1; in_rs1 = 1; in_use_rs1 = 1; ex_result = 16'h1234; regs[1] = 16'hAAAA;
    #1;
`ifdef OPERAND_FETCH_FWD_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ex_fwd_ready got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_op1 !== 16'h1234 || stall_cnt !== 16'h0) begin
      bad++; $display("FAIL ex_fwd got op1=%h cnt=%h want 1234 0", out_op1, stall_cnt); end
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ex_match_stall got=%h want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || stall_cnt !== 16'h1) begin
      bad++; $display("FAIL ex_match_bubble got v=%h cnt=%h want 0 1", out_valid, stall_cnt); end
`endif
    @(negedge clk); idle;
  endtask

  task automatic test_load_use;
    do_reset;
    @(negedge clk); idle; in_valid = 1; in_ws = 4; in_we = 1; in_is_load = 1;
    @(posedge clk);
    @(negedge clk); idle; in_valid = 1; in_rs2 = 4; in_use_rs2 = 1; regs[4] = 16'h0404; ex_result = 16'h7777;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_use_ready got=%h want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL load_use_bubble got=%h want=0", out_valid); end
    @(negedge clk); mem_valid = 1; mem_we = 1; mem_ws = 4; mem_wd = 16'hBEEF;
    #1;
`ifdef OPERAND_FETCH_FWD_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_use_release got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_op2 !== 16'hBEEF || stall_cnt !== 16'h1) begin
      bad++; $display("FAIL load_use_fwd got v=%h op2=%h cnt=%h want 1 beef 1", out_valid, out_op2, stall_cnt); end
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mem_match_stall got=%h want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 16'h2) begin bad++; $display("FAIL mem_match_cnt got=%h want=2", stall_cnt); end
`endif
    @(negedge clk); idle;
  endtask

  task automatic test_mem_wb_priority;
    do_reset;
    @(negedge clk); idle; regs[5] = 16'h5555;
    in_valid = 1; in_rs1 = 5; in_use_rs1 = 1;
    mem_valid = 1; mem_we = 1; mem_ws = 5; mem_wd = 16'h0005;
    wb_we = 1; wb_ws = 5; wb_wd = 16'h0009;
    #1;
`ifdef OPERAND_FETCH_FWD_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL memwb_ready got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_op1 !== 16'h0005) begin bad++; $display("FAIL mem_over_wb got=%h want=0005", out_op1); end
    @(negedge clk); mem_valid = 0; #1;
    @(posedge clk); #1;
    total++; if (out_op1 !== 16'h0009) begin bad++; $display("FAIL wb_only got=%h want=0009", out_op1); end
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL memwb_stall got=%h want=0", in_ready); end
    @(negedge clk); mem_valid = 0; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL wb_stall got=%h want=0", in_ready); end
`endif
    @(negedge clk); idle;
  endtask

  task automatic test_back_to_back;
    do_reset;
    @(negedge clk); idle; regs[1] = 16'h0101; regs[2] = 16'h0202;
    in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_use_rs1 = 1; in_use_rs2 = 1; in_ws = 7; in_is_load = 1;
    @(posedge clk);
    @(negedge clk); out_ready = 0; regs[3] = 16'h0303; regs[4] = 16'h0404;
    in_rs1 = 3; in_rs2 = 4; in_ws = 2; in_we = 1; in_is_load = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%h want=0", i, in_ready); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_op1 !== 16'h0101 || out_op2 !== 16'h0202 || out_ws !== 3'd7 || out_is_load !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%h %h %h ws=%h ld=%h want 1 0101 0202 7 1",
                        i, out_valid, out_op1, out_op2, out_ws, out_is_load);
      end
      @(negedge clk);
      regs[1] = 16'(i + 16'h0E00);
    end
    out_ready = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h0303 || out_op2 !== 16'h0404 || out_ws !== 3'd2 ||
        out_we !== 1'b1 || stall_cnt !== 16'd3) begin
      bad++; $display("FAIL bp_next got v=%h %h %h ws=%h we=%h cnt=%h want 1 0303 0404 2 1 3",
                      out_valid, out_op1, out_op2, out_ws, out_we, stall_cnt);
    end
    @(negedge clk); idle;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%h want=0", out_valid); end
  endtask

  task automatic test_wb_write;
    do_reset;
    @(negedge clk); idle; regs[6] = 16'h1111;
    in_valid = 1; in_rs1 = 6; in_use_rs1 = 1; wb_we = 1; wb_ws = 6; wb_wd = 16'h6666;
    #1;
`ifdef OPERAND_FETCH_FWD_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wb_fwd_ready got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_op1 !== 16'h6666) begin bad++; $display("FAIL wb_fwd got=%h want=6666", out_op1); end
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL wb_stall got=%h want=0", in_ready); end
    @(posedge clk); #1; regs[6] = 16'h6666;
    @(negedge clk); wb_we = 0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wb_release got=%h want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_op1 !== 16'h6666 || stall_cnt !== 16'h1) begin
      bad++; $display("FAIL wb_written got op1=%h cnt=%h want 6666 1", out_op1, stall_cnt); end
`endif
    @(negedge clk); idle;
  endtask

  task automatic test_random;
    logic e_ready;
    logic [15:0] e_op1, e_op2;
    do_reset;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_ws = 0; m_we = 0; m_load = 0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_ws = 3'($urandom);
      in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
      in_we = 1'($urandom); in_is_load = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ex_result = 16'($urandom);
      mem_valid = ($urandom_range(0, 2) == 0); mem_we = 1'($urandom);
      mem_ws = 3'($urandom); mem_wd = 16'($urandom);
      wb_we = ($urandom_range(0, 3) == 0); wb_ws = 3'($urandom); wb_wd = 16'($urandom);
      if ($urandom_range(0, 1) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
      #1;
      total++;
      if (out_valid !== m_valid || out_op1 !== m_op1 || out_op2 !== m_op2 || out_ws !== m_ws ||
          out_we !== m_we || out_is_load !== m_load || stall_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rand_out[%0d] got v=%h %h %h ws=%h we=%h ld=%h cnt=%h want v=%h %h %h ws=%h we=%h ld=%h cnt=%h",
                        c, out_valid, out_op1, out_op2, out_ws, out_we, out_is_load, stall_cnt,
                        m_valid, m_op1, m_op2, m_ws, m_we, m_load, 16'(m_cnt));
      end
      e_ready = !((in_use_rs1 && blocks(in_rs1)) || (in_use_rs2 && blocks(in_rs2))) && (!m_valid || out_ready);
      e_op1 = in_use_rs1 ? pick(in_rs1) : regs[in_rs1];
      e_op2 = in_use_rs2 ? pick(in_rs2) : regs[in_rs2];
      total++;
      if (in_ready !== e_ready || rf_rs1 !== in_rs1 || rf_rs2 !== in_rs2) begin
        bad++; $display("FAIL rand_ready[%0d] got=%h rf=%h/%h want=%h rf=%h/%h",
                        c, in_ready, rf_rs1, rf_rs2, e_ready, in_rs1, in_rs2);
      end
      if (in_valid && !e_ready && m_cnt < 65535) m_cnt++;
      if (in_valid && e_ready) begin
        m_valid = 1; m_op1 = e_op1; m_op2 = e_op2; m_ws = in_ws; m_we = in_we; m_load = in_is_load;
      end else if (out_ready) begin
        m_valid = 0;
      end
      @(posedge clk);
    end
    @(negedge clk); idle;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);
    idle;
    reset = 1;
    test_reset;
    test_basic;
    test_forward_ex;
    test_load_use;
    test_mem_wb_priority;
    test_back_to_back;
    test_wb_write;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
